// File: rtl/send_sched_pkg.sv
// Shared types and sizing helpers for the telemetry frame scheduler.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package send_sched_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP
  } state_e;

  typedef enum logic [1:0] {
    SLOT_FAULT,
    SLOT_FRE,
    SLOT_STATE,
    SLOT_VOLT
  } slot_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Counter widths for the default parameter set.
  localparam int TMR_W_DEF = cnt_w(20000);
  localparam int GAP_W_DEF = cnt_w(64);
  localparam int ACK_W_DEF = cnt_w(16);

  // Telemetry round-robin order: FRE -> STATE -> VOLT -> FRE.
  function automatic slot_e next_slot(input slot_e s);
    case (s)
      SLOT_FRE:   return SLOT_STATE;
      SLOT_STATE: return SLOT_VOLT;
      default:    return SLOT_FRE;
    endcase
  endfunction

endpackage

// File: rtl/send_sched_if.sv
// Scheduler-to-sender bus: frame enable pulses, data snapshots, busy feedback.
// Latency: wires only.
// Backpressure: tx_busy from the sender holds off the next frame.
interface send_sched_if;
  import send_sched_pkg::*;

  logic              fault_en;
  logic              fre_en;
  logic              state_en;
  logic              volt_en;
  logic [DATA_W-1:0] fre_data;
  logic [DATA_W-1:0] state;
  logic [DATA_W-1:0] volt;
  logic              tx_busy;

  modport master (
    output fault_en, fre_en, state_en, volt_en,
    output fre_data, state, volt,
    input  tx_busy
  );

  modport slave (
    input  fault_en, fre_en, state_en, volt_en,
    input  fre_data, state, volt,
    output tx_busy
  );

endinterface

// File: rtl/send_sched_tmr.sv
// Periodic telemetry slot timer with a single, non-queueing pending flag.
// Latency: tel_pend rises on the edge where the count wraps from PERIOD_CYC-1.
// Backpressure: a wrap while tel_pend is still set is dropped; sched_en=0 clears.
module send_sched_tmr
  import send_sched_pkg::*;
#(
  parameter int PERIOD_CYC = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sched_en,
  input  logic tel_clr,
  output logic tel_pend
);

  localparam int             TMR_W = cnt_w(PERIOD_CYC);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(PERIOD_CYC - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             wrap;

  // Next count and pending flag; clearing wins because a set flag drops wraps anyway.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    wrap   = 1'b0;
    if (!sched_en) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + TMR_W'(1);
      end
      pend_d = tel_clr ? 1'b0 : (pend_q | wrap);
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign tel_pend = pend_q;

endmodule

// File: rtl/send_sched.sv
// Frame scheduler for the telemetry sender: fault-priority, round-robin telemetry.
// Latency: pend set at edge N -> enable pulse registered at edge N+1 (one cycle wide).
// Backpressure: no frame starts while tx_busy is high; each frame ends with GAP_CYC idle.
// Optional SEND_SCHED_STAT_EN adds tx_cnt (completed frames) and err_cnt (ack timeouts).
module send_sched
  import send_sched_pkg::*;
#(
  parameter int PERIOD_CYC = 20000,
  parameter int GAP_CYC    = 64,
  parameter int ACK_TO     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sched_en,
  input  logic              fault_req,
  input  logic [DATA_W-1:0] fre_in,
  input  logic [DATA_W-1:0] state_in,
  input  logic [DATA_W-1:0] volt_in,
  send_sched_if.master      tx,
  output logic              sched_busy,
  output logic              ack_err
`ifdef SEND_SCHED_STAT_EN
  ,
  output logic [15:0]       tx_cnt,
  output logic [7:0]        err_cnt
`endif
);

  localparam int               GAP_W    = cnt_w(GAP_CYC);
  localparam int               ACK_W    = cnt_w(ACK_TO);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TO - 1);

  state_e            state_q, state_d;
  slot_e             slot_q, slot_d;
  slot_e             ptr_q, ptr_d;
  logic              fault_pend_q, fault_pend_d;
  logic              fault_req_q;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic [DATA_W-1:0] snap_fre_q, snap_fre_d;
  logic [DATA_W-1:0] snap_state_q, snap_state_d;
  logic [DATA_W-1:0] snap_volt_q, snap_volt_d;
  logic              fault_en_q, fault_en_d;
  logic              fre_en_q, fre_en_d;
  logic              state_en_q, state_en_d;
  logic              volt_en_q, volt_en_d;
  logic              sched_busy_q, sched_busy_d;
  logic              ack_err_q, ack_err_d;
  logic              tel_pend;
  logic              tel_clr;
  logic              issue;
  logic              fault_rise;

  assign fault_rise = fault_req & ~fault_req_q;

  send_sched_tmr #(
    .PERIOD_CYC (PERIOD_CYC)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .sched_en (sched_en),
    .tel_clr  (tel_clr),
    .tel_pend (tel_pend)
  );

  // Next-state logic: frame selection, handshake tracking and gap timing.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    ptr_d        = ptr_q;
    fault_pend_d = fault_pend_q;
    gap_cnt_d    = gap_cnt_q;
    ack_cnt_d    = ack_cnt_q;
    snap_fre_d   = snap_fre_q;
    snap_state_d = snap_state_q;
    snap_volt_d  = snap_volt_q;
    ack_err_d    = 1'b0;
    tel_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Foreign activity on the sender also blocks a new frame.
        if (!tx.tx_busy && (fault_pend_q || tel_pend)) begin
          state_d      = ST_ISSUE;
          slot_d       = fault_pend_q ? SLOT_FAULT : ptr_q;
          snap_fre_d   = fre_in;
          snap_state_d = state_in;
          snap_volt_d  = volt_in;
        end
      end
      ST_ISSUE: begin
        if (slot_q == SLOT_FAULT) begin
          fault_pend_d = 1'b0;
        end else begin
          tel_clr = 1'b1;
          ptr_d   = next_slot(ptr_q);
        end
        ack_cnt_d = '0;
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          // Sender never answered; give up on this frame but keep the pointer moving.
          ack_err_d = 1'b1;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx.tx_busy) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new fault edge always re-arms, even on the cycle the flag is serviced.
    if (fault_rise) begin
      fault_pend_d = 1'b1;
    end

    issue        = (state_q == ST_IDLE) && (state_d == ST_ISSUE);
    fault_en_d   = issue && (slot_d == SLOT_FAULT);
    fre_en_d     = issue && (slot_d == SLOT_FRE);
    state_en_d   = issue && (slot_d == SLOT_STATE);
    volt_en_d    = issue && (slot_d == SLOT_VOLT);
    sched_busy_d = (state_d != ST_IDLE);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= SLOT_FRE;
      ptr_q        <= SLOT_FRE;
      fault_pend_q <= 1'b0;
      fault_req_q  <= 1'b0;
      gap_cnt_q    <= '0;
      ack_cnt_q    <= '0;
      snap_fre_q   <= '0;
      snap_state_q <= '0;
      snap_volt_q  <= '0;
      fault_en_q   <= 1'b0;
      fre_en_q     <= 1'b0;
      state_en_q   <= 1'b0;
      volt_en_q    <= 1'b0;
      sched_busy_q <= 1'b0;
      ack_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      ptr_q        <= ptr_d;
      fault_pend_q <= fault_pend_d;
      fault_req_q  <= fault_req;
      gap_cnt_q    <= gap_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      snap_fre_q   <= snap_fre_d;
      snap_state_q <= snap_state_d;
      snap_volt_q  <= snap_volt_d;
      fault_en_q   <= fault_en_d;
      fre_en_q     <= fre_en_d;
      state_en_q   <= state_en_d;
      volt_en_q    <= volt_en_d;
      sched_busy_q <= sched_busy_d;
      ack_err_q    <= ack_err_d;
    end
  end

  assign tx.fault_en = fault_en_q;
  assign tx.fre_en   = fre_en_q;
  assign tx.state_en = state_en_q;
  assign tx.volt_en  = volt_en_q;
  assign tx.fre_data = snap_fre_q;
  assign tx.state    = snap_state_q;
  assign tx.volt     = snap_volt_q;
  assign sched_busy  = sched_busy_q;
  assign ack_err     = ack_err_q;

`ifdef SEND_SCHED_STAT_EN
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Completed frames wrap; timeouts saturate so a stuck sender stays visible.
  always_comb begin
    tx_cnt_d  = tx_cnt_q;
    err_cnt_d = err_cnt_q;
    if ((state_q == ST_WAIT_DONE) && !tx.tx_busy) begin
      tx_cnt_d = tx_cnt_q + 16'd1;
    end
    if (ack_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      tx_cnt_q  <= tx_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign tx_cnt  = tx_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
